// File: rtl/fft_chk_pkg.sv
// rtl/fft_chk_pkg.sv - shared types and sizing helpers for the FFT stream checker
package fft_chk_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        IN    = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } chk_state_t;

    localparam int DEFAULT_SNR_RATIO = 10000;

    // Enough headroom for FFT_SIZE error-energy terms of two (OUT_WIDTH+2)-bit squares.
    function automatic int acc_w(input int out_width, input int fft_size);
        return 2 * out_width + 5 + $clog2(fft_size);
    endfunction

endpackage

// File: rtl/fft_energy_acc.sv
// rtl/fft_energy_acc.sv - squares and accumulates golden signal energy and complex error energy
module fft_energy_acc #(
    parameter int OUT_WIDTH = 16,
    parameter int ACC_W     = 42
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   en,
    input  logic signed [OUT_WIDTH:0]   gold_r,
    input  logic signed [OUT_WIDTH:0]   gold_i,
    input  logic signed [OUT_WIDTH-1:0] dout_r,
    input  logic signed [OUT_WIDTH-1:0] dout_i,
    output logic [ACC_W-1:0]       sig,
    output logic [ACC_W-1:0]       noise
);

    localparam int EW = OUT_WIDTH + 2;
    localparam int SW = 2 * EW;

    logic signed [EW-1:0] gr, gi, nr, ni;
    logic signed [SW-1:0] gr_sq, gi_sq, nr_sq, ni_sq;
    logic [ACC_W-1:0]     sig_inc, noise_inc;

    assign gr = EW'(gold_r);
    assign gi = EW'(gold_i);
    assign nr = EW'(gold_r) - EW'(dout_r);
    assign ni = EW'(gold_i) - EW'(dout_i);

    assign gr_sq = SW'(gr) * SW'(gr);
    assign gi_sq = SW'(gi) * SW'(gi);
    assign nr_sq = SW'(nr) * SW'(nr);
    assign ni_sq = SW'(ni) * SW'(ni);

    // Squares are never negative, so reinterpreting them as unsigned is exact.
    assign sig_inc   = ACC_W'($unsigned(gr_sq)) + ACC_W'($unsigned(gi_sq));
    assign noise_inc = ACC_W'($unsigned(nr_sq)) + ACC_W'($unsigned(ni_sq));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig   <= '0;
            noise <= '0;
        end else if (clear) begin
            sig   <= '0;
            noise <= '0;
        end else if (en) begin
            sig   <= sig + sig_inc;
            noise <= noise + noise_inc;
        end
    end

endmodule

// File: rtl/fft_stream_checker.sv
// rtl/fft_stream_checker.sv - per-frame latency and SNR checker for a streaming FFT core (option: FFT_STREAM_CHECKER_STATS_EN)
module fft_stream_checker
    import fft_chk_pkg::*;
#(
    parameter int FFT_SIZE  = 32,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 16,
    parameter int LAT_LIMIT = 68,
    parameter int SNR_RATIO = DEFAULT_SNR_RATIO
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic                              out_valid,
    input  logic signed [OUT_WIDTH-1:0]       dout_r,
    input  logic signed [OUT_WIDTH-1:0]       dout_i,
    input  logic signed [OUT_WIDTH:0]         gold_r,
    input  logic signed [OUT_WIDTH:0]         gold_i,
    output logic [$clog2(FFT_SIZE)-1:0]       gold_addr,
    output logic                              done,
    output logic                              pass,
    output logic                              err_timeout,
    output logic                              err_frame,
    output logic [$clog2(LAT_LIMIT+2)-1:0]    latency,
    output logic [acc_w(OUT_WIDTH, FFT_SIZE)-1:0] sig_energy,
    output logic [acc_w(OUT_WIDTH, FFT_SIZE)-1:0] noise_energy
`ifdef FFT_STREAM_CHECKER_STATS_EN
    ,
    output logic [15:0]                       frame_cnt,
    output logic [23:0]                       lat_total
`endif
);

    localparam int AW    = $clog2(FFT_SIZE);
    localparam int CW    = AW + 1;
    localparam int LW    = $clog2(LAT_LIMIT + 2);
    localparam int ACC_W = acc_w(OUT_WIDTH, FFT_SIZE);
    localparam int PW    = ACC_W + $clog2(SNR_RATIO);

    if (FFT_SIZE < 8 || FFT_SIZE > 1024 || (FFT_SIZE & (FFT_SIZE - 1)) != 0 ||
        IN_WIDTH < 2 || OUT_WIDTH < 2 || LAT_LIMIT < 1 || SNR_RATIO < 1) begin : g_bad_param
        $error("fft_stream_checker: unsupported parameter set");
    end

    chk_state_t      state, state_nx;
    logic [CW-1:0]   in_cnt;
    logic [AW-1:0]   out_cnt;
    logic [LW-1:0]   lat_inc;
    logic            frame_start, acc_en, busy;
    logic            verdict, pass_q;
    logic [PW-1:0]   noise_scaled;

    assign lat_inc   = latency + LW'(1);
    assign gold_addr = out_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = IN;
            IN: begin
                if (in_cnt == CW'(FFT_SIZE)) state_nx = WAIT;
                else if (!in_valid)          state_nx = DONE;
            end
            WAIT, CHECK: begin
                if (out_valid) begin
                    if (out_cnt == AW'(FFT_SIZE - 1)) state_nx = DONE;
                    else                              state_nx = CHECK;
                end else if (lat_inc > LW'(LAT_LIMIT)) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = in_valid ? IN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        done        = 1'b0;
        frame_start = 1'b0;
        acc_en      = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: frame_start = in_valid;
            WAIT, CHECK: begin
                busy   = 1'b1;
                acc_en = out_valid;
            end
            DONE: begin
                done        = 1'b1;
                frame_start = in_valid;
            end
            default: ;
        endcase
    end

    // A DONE cycle that also carries in_valid restarts the frame, so clearing takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt      <= '0;
            out_cnt     <= '0;
            latency     <= '0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            pass_q      <= 1'b0;
        end else if (frame_start) begin
            in_cnt      <= CW'(1);
            out_cnt     <= '0;
            latency     <= '0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            if (state == IN) begin
                if (in_cnt == CW'(FFT_SIZE)) begin
                    if (in_valid) err_frame <= 1'b1;
                end else if (in_valid) begin
                    in_cnt <= in_cnt + CW'(1);
                end else begin
                    err_frame <= 1'b1;
                end
            end
            if (busy) begin
                if (in_valid) err_frame <= 1'b1;
                if (out_valid) begin
                    out_cnt <= out_cnt + AW'(1);
                end else begin
                    latency <= lat_inc;
                    if (lat_inc > LW'(LAT_LIMIT)) err_timeout <= 1'b1;
                end
            end
            if (done) pass_q <= verdict;
        end
    end

    fft_energy_acc #(
        .OUT_WIDTH (OUT_WIDTH),
        .ACC_W     (ACC_W)
    ) u_energy_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (frame_start),
        .en     (acc_en),
        .gold_r (gold_r),
        .gold_i (gold_i),
        .dout_r (dout_r),
        .dout_i (dout_i),
        .sig    (sig_energy),
        .noise  (noise_energy)
    );

    // Accumulators hold their final values during DONE, so the verdict is formed combinationally there.
    assign noise_scaled = PW'(noise_energy) * PW'(SNR_RATIO);
    assign verdict      = !err_timeout && !err_frame && (PW'(sig_energy) >= noise_scaled);
    assign pass         = done ? verdict : pass_q;

`ifdef FFT_STREAM_CHECKER_STATS_EN
    logic [24:0] lat_sum;

    assign lat_sum = {1'b0, lat_total} + 25'(latency);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            lat_total <= '0;
        end else if (done) begin
            if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
            lat_total <= lat_sum[24] ? 24'hFF_FFFF : lat_sum[23:0];
        end
    end
`endif

endmodule
